// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests into stall/bubble vectors,
// sequences exception flush with redirect PC, and tracks stall watchdog/perf counter.
module pipe_ctrl #(
    parameter int NSTAGE       = 6,
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CW           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              excp_valid,
    input  logic [AW-1:0]     excp_pc,
    input  logic              perf_clr,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic              flush,
    output logic [AW-1:0]     new_pc,
    output logic              stall_timeout,
    output logic [CW-1:0]     stall_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [WD_W-1:0]   wd_cnt;
    logic [NSTAGE-1:0] stall_raw;
    logic              any_stall;

    // A stage stalls whenever it or any later stage requests a stall.
    always_comb begin
        stall_raw = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            stall_raw[i] = |(stall_req >> i);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        new_pc  = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (excp_valid && !rst) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    pc_d    = excp_pc;
                    flush   = 1'b1;
                    new_pc  = excp_pc;
                end
            end
            ST_FLUSH: begin
                flush = !rst;
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset and flush both override any stall request.
    always_comb begin
        stall  = (rst || flush) ? '0 : stall_raw;
        bubble = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            bubble[k] = stall[k-1] & ~stall[k];
        end
    end

    assign any_stall = |stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fcnt_q        <= '0;
            pc_q          <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;

            // Timeout latches on the edge that completes TIMEOUT consecutive stalls.
            if (any_stall) begin
                if (wd_cnt != WD_W'(TIMEOUT)) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                if (wd_cnt >= WD_W'(TIMEOUT - 1)) begin
                    stall_timeout <= 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end

            if (perf_clr) begin
                stall_cnt <= '0;
            end else if (any_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts each cycle's outputs.
module tb_pipe_ctrl;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] stall_req = '0;
    logic          excp_valid = 1'b0;
    logic [AW-1:0] excp_pc = '0;
    logic          perf_clr = 1'b0;
    logic [NS-1:0] stall, bubble;
    logic          flush;
    logic [AW-1:0] new_pc;
    logic          stall_timeout;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NSTAGE(NS), .AW(AW), .FLUSH_CYCLES(FC), .TIMEOUT(TO), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .perf_clr(perf_clr), .stall(stall), .bubble(bubble),
        .flush(flush), .new_pc(new_pc), .stall_timeout(stall_timeout),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [NS-1:0] st;
        logic [NS-1:0] bu;
        logic          fl;
        logic [AW-1:0] pc;
        logic          to;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int fl_seen = 0;

    int            m_left = 0;
    int            m_wd   = 0;
    int            m_cnt  = 0;
    logic          m_to   = 1'b0;
    logic [AW-1:0] m_pc   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [NS-1:0] req, input logic ev, input logic [AW-1:0] epc,
                        input logic clr, input logic r);
        exp_t e;
        exp_t g;
        int   hk;
        logic acc;
        @(posedge clk);
        #1;
        stall_req  = req;
        excp_valid = ev;
        excp_pc    = epc;
        perf_clr   = clr;
        rst        = r;

        acc  = !r && (m_left == 0) && ev;
        e.fl = !r && ((m_left > 0) || acc);
        e.pc = acc ? epc : m_pc;
        hk = -1;
        for (int k = 0; k < NS; k++) if (req[k]) hk = k;
        e.st  = (r || e.fl || hk < 0) ? '0 : NS'((1 << (hk + 1)) - 1);
        e.bu  = NS'(e.st << 1) & ~e.st;
        e.to  = m_to;
        e.cnt = CW'(m_cnt);
        q.push_back(e);

        if (r) begin
            m_left = 0; m_pc = '0; m_wd = 0; m_to = 1'b0; m_cnt = 0;
        end else begin
            if (acc) begin
                m_left = FC;
                m_pc   = epc;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (e.st != 0) begin
                m_wd++;
                if (m_wd >= TO) m_to = 1'b1;
                if (m_wd > TO) m_wd = TO;
            end else begin
                m_wd = 0;
            end
            if (clr) m_cnt = 0;
            else if (e.st != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
        end

        @(negedge clk);
        g = q.pop_front();
        chk("stall", 64'(stall), 64'(g.st));
        chk("bubble", 64'(bubble), 64'(g.bu));
        chk("flush", 64'(flush), 64'(g.fl));
        chk("new_pc", 64'(new_pc), 64'(g.pc));
        chk("stall_timeout", 64'(stall_timeout), 64'(g.to));
        chk("stall_cnt", 64'(stall_cnt), 64'(g.cnt));
        if (flush === 1'b1) fl_seen++;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step('0, 0, '0, 0, 1);

        // Single requests and extreme request patterns
        step(6'b000100, 0, '0, 0, 0);
        chk("stall_id", 64'(stall), 64'h07);
        chk("bubble_id", 64'(bubble), 64'h08);
        step(6'b001100, 0, '0, 0, 0);
        chk("stall_ex", 64'(stall), 64'h0F);
        step(6'b000000, 0, '0, 0, 0);
        step(6'b111111, 0, '0, 0, 0);
        chk("bubble_all", 64'(bubble), 64'h00);
        step(6'b100000, 0, '0, 0, 0);
        step(6'b000001, 0, '0, 0, 0);
        step(6'b000000, 0, '0, 0, 0);

        // Watchdog: 3 stalled, 1 free, 3 stalled must not trip
        repeat (3) step(6'b000010, 0, '0, 0, 0);
        step('0, 0, '0, 0, 0);
        repeat (3) step(6'b000010, 0, '0, 0, 0);
        step('0, 0, '0, 0, 0);
        chk("wd_no_trip", 64'(stall_timeout), 64'h0);
        repeat (4) step(6'b000010, 0, '0, 0, 0);
        step('0, 0, '0, 0, 0);
        chk("wd_trip", 64'(stall_timeout), 64'h1);
        step('0, 0, '0, 0, 0);
        chk("wd_sticky", 64'(stall_timeout), 64'h1);

        // Perf counter: clear with stall, count, saturate
        step('0, 0, '0, 0, 1);
        step(6'b000010, 0, '0, 1, 0);
        step('0, 0, '0, 0, 0);
        chk("cnt_clr", 64'(stall_cnt), 64'h0);
        repeat (10) step(6'b000010, 0, '0, 0, 0);
        step('0, 0, '0, 0, 0);
        chk("cnt_10", 64'(stall_cnt), 64'd10);
        repeat (10) step(6'b000010, 0, '0, 0, 0);
        step('0, 0, '0, 0, 0);
        chk("cnt_sat", 64'(stall_cnt), 64'd15);

        // Exception flush with a held EX stall and an ignored second exception
        step('0, 0, '0, 0, 1);
        step(6'b001000, 0, '0, 0, 0);
        fl_seen = 0;
        step(6'b001000, 1, 32'hBFC00380, 0, 0);
        step(6'b001000, 1, 32'h80000180, 0, 0);
        step(6'b001000, 0, '0, 0, 0);
        step(6'b001000, 0, '0, 0, 0);
        chk("flush_len", 64'(fl_seen), 64'd3);
        chk("stall_after_flush", 64'(stall), 64'h0F);
        chk("pc_hold", 64'(new_pc), 64'hBFC00380);

        // Reset in the second flush cycle aborts the flush
        step('0, 1, 32'hA0000000, 0, 0);
        step('0, 0, '0, 0, 1);
        step('0, 0, '0, 0, 0);
        chk("rst_abort_flush", 64'(flush), 64'h0);
        chk("rst_abort_pc", 64'(new_pc), 64'h0);
        step(6'b000100, 1, 32'h12345678, 0, 0);
        chk("reaccept_flush", 64'(flush), 64'h1);
        chk("reaccept_pc", 64'(new_pc), 64'h12345678);
        repeat (3) step(6'b000100, 0, '0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
